// File: rtl/pixel_row_sequencer.sv
// Frame sequencer: global erase, programmable exposure, then row-by-row ADC readout.
// Define PIXSEQ_ADC_TIMEOUT_EN to abort a frame when the ADC never answers.
module pixel_row_sequencer #(
  parameter int ROWS        = 4,
  parameter int ROW_W       = 2,
  parameter int EXP_W       = 8,
  parameter int ERASE_CYC   = 2,
  parameter int ADC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [EXP_W-1:0] exposure_len,
  input  logic             adc_done,
  output logic             busy,
  output logic             erase,
  output logic             expose,
  output logic             bias_en,
  output logic             adc_start,
  output logic [ROWS-1:0]  row_sel,
  output logic [ROW_W-1:0] row_idx,
  output logic             frame_done,
  output logic             err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ERASE   = 3'd1;
  localparam logic [2:0] S_EXPOSE  = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_CONVERT = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int ER_W = $clog2(ERASE_CYC + 1);

  if (ROWS < 1 || ERASE_CYC < 1 || ADC_TIMEOUT < 1 || (2 ** ROW_W) < ROWS) begin : g_bad_params
    $error("pixel_row_sequencer: illegal parameter combination");
  end

  logic [2:0]       r_state;
  logic [ROW_W-1:0] r_row_idx;
  logic [EXP_W-1:0] r_exp_cnt;
  logic [ER_W-1:0]  r_er_cnt;
  logic             r_busy, r_erase, r_expose, r_adc_start, r_frame_done;
  logic [ROWS-1:0]  r_row_sel;

  logic [2:0]       w_nxt_state;
  logic [ROW_W-1:0] w_nxt_row;
  logic [ROWS-1:0]  w_onehot;
  logic             w_accept;

`ifdef PIXSEQ_ADC_TIMEOUT_EN
  localparam int TO_W = $clog2(ADC_TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  logic            w_timeout;
`endif

  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_row   = r_row_idx;
`ifdef PIXSEQ_ADC_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (start) begin
        w_nxt_state = S_ERASE;
        w_nxt_row   = '0;
      end
      S_ERASE:  if (r_er_cnt == ER_W'(ERASE_CYC - 1)) w_nxt_state = S_EXPOSE;
      S_EXPOSE: if (r_exp_cnt == EXP_W'(1)) w_nxt_state = S_START;
      S_START:  w_nxt_state = S_CONVERT;
      S_CONVERT: begin
        if (adc_done) w_nxt_state = S_NEXT;
`ifdef PIXSEQ_ADC_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(ADC_TIMEOUT - 1)) begin
          w_nxt_state = S_IDLE;
          w_timeout   = 1'b1;
        end
`endif
      end
      S_NEXT: begin
        if (r_row_idx == ROW_W'(ROWS - 1)) w_nxt_state = S_DONE;
        else begin
          w_nxt_state = S_START;
          w_nxt_row   = r_row_idx + ROW_W'(1);
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < ROWS; i++) w_onehot[i] = (w_nxt_row == ROW_W'(i));
  end

  // Outputs are decoded from the next state so each one is a plain register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_row_idx    <= '0;
      r_exp_cnt    <= '0;
      r_er_cnt     <= '0;
      r_busy       <= 1'b0;
      r_erase      <= 1'b0;
      r_expose     <= 1'b0;
      r_adc_start  <= 1'b0;
      r_row_sel    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_row_idx    <= w_nxt_row;
      r_busy       <= (w_nxt_state != S_IDLE);
      r_erase      <= (w_nxt_state == S_ERASE);
      r_expose     <= (w_nxt_state == S_EXPOSE);
      r_adc_start  <= (w_nxt_state == S_START);
      r_row_sel    <= (w_nxt_state == S_START || w_nxt_state == S_CONVERT) ? w_onehot : '0;
      r_frame_done <= (w_nxt_state == S_DONE);
      if (w_accept) begin
        r_exp_cnt <= (exposure_len == '0) ? EXP_W'(1) : exposure_len;
        r_er_cnt  <= '0;
      end else begin
        if (r_state == S_ERASE)  r_er_cnt  <= r_er_cnt + ER_W'(1);
        if (r_state == S_EXPOSE) r_exp_cnt <= r_exp_cnt - EXP_W'(1);
      end
    end
  end

`ifdef PIXSEQ_ADC_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == S_CONVERT) ? r_to_cnt + TO_W'(1) : '0;
      if (w_accept)       r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy       = r_busy;
  assign erase      = r_erase;
  assign expose     = r_expose;
  assign bias_en    = r_expose;
  assign adc_start  = r_adc_start;
  assign row_sel    = r_row_sel;
  assign row_idx    = r_row_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_row_sequencer.sv
// Directed bench for pixel_row_sequencer (ROWS=4, ERASE_CYC=2, ADC_TIMEOUT=16).
module tb_pixel_row_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] exposure_len = 8'd0;
  logic       adc_done = 1'b0;
  logic       busy, erase, expose, bias_en, adc_start, frame_done, err;
  logic [3:0] row_sel;
  logic [1:0] row_idx;

  int checks = 0;
  int failures = 0;

  // Per-frame observations
  int c, s, c_end, n_erase, f_erase, n_expose, f_expose, n_bias_bad, n_fd, f_fd;
  int n_busy, n_rs, n_st;
  int st[8];
  logic [15:0] rs_seq;
  logic [7:0]  ri_seq;
  int n_fd_idle;

  pixel_row_sequencer #(
    .ROWS(4), .ROW_W(2), .EXP_W(8), .ERASE_CYC(2), .ADC_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .exposure_len(exposure_len),
    .adc_done(adc_done), .busy(busy), .erase(erase), .expose(expose),
    .bias_en(bias_en), .adc_start(adc_start), .row_sel(row_sel),
    .row_idx(row_idx), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame from IDLE and records the cycle-by-cycle output pattern.
  // dly: adc_done pulses this many cycles after each adc_start (tie_hi keeps it high).
  task run_frame(input logic [7:0] len, input int dly, input bit tie_hi, input bit noise);
    exposure_len = len;
    start = 1'b1;
    adc_done = tie_hi | noise;
    c = 0; s = -100; c_end = -1;
    n_erase = 0; f_erase = -1; n_expose = 0; f_expose = -1; n_bias_bad = 0;
    n_fd = 0; f_fd = -1; n_busy = 0; n_rs = 0; n_st = 0;
    rs_seq = '0; ri_seq = '0;
    while (c < 200 && c_end < 0) begin
      tick();
      c++;
      start = 1'b0;
      exposure_len = 8'hA5;
      adc_done = tie_hi;
      if (erase) begin n_erase++; if (f_erase < 0) f_erase = c; end
      if (expose) begin n_expose++; if (f_expose < 0) f_expose = c; end
      if (bias_en !== expose) n_bias_bad++;
      if (frame_done) begin n_fd++; f_fd = c; end
      if (busy) n_busy++;
      if (row_sel != 4'd0) n_rs++;
      if (adc_start) begin
        if (n_st < 8) st[n_st] = c;
        n_st++;
        rs_seq = {rs_seq[11:0], row_sel};
        ri_seq = {ri_seq[5:0], row_idx};
        s = c;
      end
      if (!tie_hi && c == s + dly) adc_done = 1'b1;
      if (noise && c == s + 1) start = 1'b1;
      if (noise && expose) adc_done = 1'b1;
      if (!busy) c_end = c;
    end
    start = 1'b0;
    adc_done = 1'b0;
    chk("frame_terminates", (c_end > 0), 1);
  endtask

  task automatic check_baseline(input string pfx);
    chk({pfx, "_erase_first"}, f_erase, 1);
    chk({pfx, "_erase_cycles"}, n_erase, 2);
    chk({pfx, "_expose_first"}, f_expose, 3);
    chk({pfx, "_expose_cycles"}, n_expose, 5);
    chk({pfx, "_bias_eq_expose"}, n_bias_bad, 0);
    chk({pfx, "_adc_start_count"}, n_st, 4);
    chk({pfx, "_adc_start_first"}, st[0], 8);
    chk({pfx, "_adc_start_last"}, st[3], 20);
    chk({pfx, "_row_sel_seq"}, rs_seq, 16'h1248);
    chk({pfx, "_row_idx_seq"}, ri_seq, 8'h1B);
    chk({pfx, "_row_sel_cycles"}, n_rs, 12);
    chk({pfx, "_frame_done_count"}, n_fd, 1);
    chk({pfx, "_frame_done_cycle"}, f_fd, 24);
    chk({pfx, "_busy_cycles"}, n_busy, 24);
    chk({pfx, "_idle_cycle"}, c_end, 25);
    chk({pfx, "_row_idx_hold"}, row_idx, 3);
    chk({pfx, "_err_low"}, err, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("reset_outputs", {busy, erase, expose, bias_en, adc_start, row_sel, row_idx, frame_done, err}, 13'd0);
    reset = 1'b0;
    tick();
    chk("idle_outputs", {busy, erase, expose, bias_en, adc_start, row_sel, row_idx, frame_done, err}, 13'd0);

    // Baseline: exposure 5, done two cycles after each adc_start
    run_frame(8'd5, 2, 1'b0, 1'b0);
    check_baseline("base");

    // Exposure of zero behaves as one; immediate done
    run_frame(8'd0, 1, 1'b0, 1'b0);
    chk("exp0_expose_cycles", n_expose, 1);
    chk("exp0_expose_first", f_expose, 3);
    chk("exp0_adc_start_first", st[0], 4);
    chk("exp0_adc_start_last", st[3], 13);
    chk("exp0_row_sel_cycles", n_rs, 8);
    chk("exp0_frame_done_cycle", f_fd, 16);
    chk("exp0_idle_cycle", c_end, 17);

    // Stray adc_done in IDLE, then a frame with stray start/adc_done pulses
    adc_done = 1'b1;
    tick();
    adc_done = 1'b0;
    chk("idle_adc_done_ignored", {busy, adc_start, row_sel}, 6'd0);
    run_frame(8'd5, 2, 1'b0, 1'b1);
    check_baseline("noise");

    // adc_done tied high: rows every 3 cycles
    run_frame(8'd5, 0, 1'b1, 1'b0);
    chk("tie_adc_start_count", n_st, 4);
    chk("tie_adc_start_first", st[0], 8);
    for (int i = 1; i < 4; i++) chk($sformatf("tie_gap%0d", i), st[i] - st[i-1], 3);
    chk("tie_row_sel_seq", rs_seq, 16'h1248);
    chk("tie_row_sel_cycles", n_rs, 8);
    chk("tie_frame_done_cycle", f_fd, 20);
    chk("tie_idle_cycle", c_end, 21);

    // Asynchronous reset in the middle of EXPOSE
    exposure_len = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("midexp_expose_before_reset", {expose, busy}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("midexp_async_clear", {busy, erase, expose, bias_en, adc_start, row_sel, row_idx, frame_done, err}, 13'd0);
    tick();
    reset = 1'b0;
    n_fd_idle = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (frame_done || busy) n_fd_idle++;
    end
    chk("midexp_stays_idle", n_fd_idle, 0);

    // CONVERT with no adc_done
    exposure_len = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 2; i <= 20; i++) tick();
    chk("stall_c20_busy", busy, 1);
    chk("stall_c20_row_sel", row_sel, 4'b0001);
    chk("stall_c20_err", err, 0);
    tick();
`ifdef PIXSEQ_ADC_TIMEOUT_EN
    chk("timeout_err_set", err, 1);
    chk("timeout_busy_low", busy, 0);
    chk("timeout_row_sel_clear", row_sel, 4'd0);
    n_fd_idle = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (frame_done) n_fd_idle++;
    end
    chk("timeout_no_frame_done", n_fd_idle, 0);
    chk("timeout_err_sticky", err, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("timeout_err_cleared", {err, busy, erase}, 3'b011);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("wait_busy", busy, 1);
    chk("wait_row_sel", row_sel, 4'b0001);
    chk("wait_err_tied_low", {err, frame_done, adc_start}, 3'd0);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("final_reset_idle", {busy, row_sel, err}, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_row_sequencer.md
# pixel_row_sequencer

Parametrised frame sequencer for the pixel array: on a start request it runs one global erase, a programmable exposure, then a row-by-row readout, handing each row to the SAR ADC through a start/done handshake. Generalises the fixed 2×2, fixed-exposure controller to any row count, run-time exposure length, programmable erase width and explicit frame-level handshakes. Sits between the top-level control FSM and the row decoder/ADC data path.

## Interface
- `ROWS`, 4: number of pixel rows read per frame (≥1).
- `ROW_W`, 2: width of `row_idx`; must satisfy 2**ROW_W ≥ ROWS.
- `EXP_W`, 8: width of the exposure-length input.
- `ERASE_CYC`, 2: cycles `erase` is held high (≥1).
- `ADC_TIMEOUT`, 64: max CONVERT cycles before abort (used only with the macro).

- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: frame request, sampled only in IDLE.
- `exposure_len` in EXP_W: exposure cycles, latched when `start` accepted.
- `adc_done` in 1: ADC conversion complete, accepted only in CONVERT.
- `busy` out 1: high in every state except IDLE.
- `erase` out 1: pixel erase.
- `expose` out 1: pixel expose.
- `bias_en` out 1: analog bias enable, equals `expose` (no clock gating).
- `adc_start` out 1: one-cycle conversion request.
- `row_sel` out ROWS: one-hot row select.
- `row_idx` out ROW_W: current row index.
- `frame_done` out 1: one-cycle pulse on successful frame completion.
- `err` out 1: sticky ADC timeout flag.

## Operation
- All outputs registered. Reset value of every output and counter: 0; state IDLE. Reset mid-frame aborts immediately; no `frame_done`.
- States: IDLE, ERASE, EXPOSE, START, CONVERT, NEXT, DONE.
- IDLE: `start`=1 → latch `exposure_len` (0 treated as 1), clear `err`, clear `row_idx`, → ERASE.
- ERASE: `erase`=1 for ERASE_CYC cycles → EXPOSE.
- EXPOSE: `expose`=`bias_en`=1 for latched exposure cycles → START.
- START: `adc_start`=1 for one cycle, `row_sel`=one-hot(`row_idx`) → CONVERT.
- CONVERT: `row_sel` held; `adc_done`=1 → NEXT.
- NEXT: `row_sel`=0; if `row_idx`==ROWS-1 → DONE, else `row_idx`+1 → START.
- DONE: `frame_done`=1 for one cycle → IDLE.
- `row_sel` is 0 outside START/CONVERT; `row_idx` holds last row until next accepted `start`.
- `start` while `busy` ignored (no queuing). `adc_done` outside CONVERT ignored. `start` and `adc_done` simultaneously in IDLE: frame starts, `adc_done` ignored.
- Counters saturate-free: exposure counter is EXP_W bits, erase counter sized by $clog2(ERASE_CYC+1).

## Timing
- `start` sampled at edge 0 → `erase` high from edge 1 for ERASE_CYC cycles.
- `expose` high for exactly N cycles (N = latched length, min 1), immediately after `erase` falls.
- `adc_start` rises the cycle after `expose` falls.
- `adc_done` sampled at edge k in CONVERT → NEXT at k+1 → next `adc_start` at k+2 (3-cycle minimum per row with immediate done).
- `frame_done` one cycle after final NEXT; `busy` low the cycle after `frame_done`.
- Minimum frame: 1 + ERASE_CYC + N + 3·ROWS + 1 cycles.

## Configuration
- `PIXSEQ_ADC_TIMEOUT_EN` defined: cycle counter runs in CONVERT; reaching ADC_TIMEOUT cycles without `adc_done` sets `err`=1, clears `row_sel`, → IDLE without `frame_done`. `err` stays high until reset or next accepted `start`.
- Not defined: CONVERT waits indefinitely; `err` tied 0; no timeout counter synthesised.

## Test plan
- Reset asserted mid-EXPOSE → all outputs 0 within the same cycle, state IDLE, no `frame_done`.
- ROWS=4, `exposure_len`=5, ADC returns done 2 cycles after each `adc_start` → `erase` 2 cycles, `expose` exactly 5 cycles, 4 `adc_start` pulses with `row_sel` 0001, 0010, 0100, 1000, one `frame_done`.
- `exposure_len`=0 → `expose` high exactly 1 cycle.
- `start` pulsed during CONVERT and `adc_done` pulsed in IDLE/EXPOSE → no effect; frame sequence identical to baseline.
- `adc_done` tied high in CONVERT → consecutive `adc_start` pulses exactly 3 cycles apart.
- With `PIXSEQ_ADC_TIMEOUT_EN`, ADC_TIMEOUT=16, `adc_done` never asserted → `err`=1 after 16 CONVERT cycles, `busy` low next cycle, no `frame_done`; next `start` clears `err`.
